// File: rtl/fp_mac_pkg.sv
// rtl/fp_mac_pkg.sv - shared FP MAC constants and the exponent/sign side-band tag type
package fp_mac_pkg;

  localparam int EXP_W         = 8;
  localparam int SIGN_W        = 1;
  localparam int TAG_W         = EXP_W + SIGN_W;
  localparam int MUL_STAGE_LAT = 10;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
  } fp_tag_t;

endpackage

// File: rtl/fp_tag_stage.sv
// rtl/fp_tag_stage.sv - one valid-tagged register slice of the side-band delay line
module fp_tag_stage #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  // Flush only drops the valid bit; data keeps shifting-free contents until the next advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fp_tag_delay_pipe.sv
// rtl/fp_tag_delay_pipe.sv - stallable/flushable tag delay line; FP_TAG_DELAY_PARITY_EN adds per-stage parity
module fp_tag_delay_pipe
  import fp_mac_pkg::*;
#(
  parameter int WIDTH = TAG_W,
  parameter int DEPTH = MUL_STAGE_LAT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] inflight,
  output logic             parity_err
);

`ifdef FP_TAG_DELAY_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SW = WIDTH + PAR_W;

  logic [DEPTH:0] vchain;
  logic [SW-1:0]  dchain [DEPTH+1];

  // Parity rides in the MSB of the stored word so the slices stay width-generic.
`ifdef FP_TAG_DELAY_PARITY_EN
  assign dchain[0] = {^in_data, in_data};
`else
  assign dchain[0] = in_data;
`endif
  assign vchain[0] = in_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    fp_tag_stage #(
      .WIDTH(SW)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .stall  (stall),
      .flush  (flush),
      .valid_d(vchain[i]),
      .data_d (dchain[i]),
      .valid_q(vchain[i+1]),
      .data_q (dchain[i+1])
    );
  end

  assign out_valid = vchain[DEPTH];
  assign out_data  = dchain[DEPTH][WIDTH-1:0];

`ifdef FP_TAG_DELAY_PARITY_EN
  assign parity_err = out_valid & ((^out_data) != dchain[DEPTH][WIDTH]);
`else
  assign parity_err = 1'b0;
`endif

  // Enter and leave on the same advance cancel, so the count cannot exceed DEPTH.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      inflight <= '0;
    end else if (!stall) begin
      inflight <= inflight + CNT_W'(in_valid) - CNT_W'(out_valid);
    end
  end

endmodule
